// File: rtl/axil_time_meter_pkg.sv
// Shared definitions for the AXI4-Lite time meter: register offsets,
// response codes, FSM state types and a byte-strobe merge helper.
package axil_time_meter_pkg;

    localparam logic [7:0] OFS_ID       = 8'h00;
    localparam logic [7:0] OFS_CTRL     = 8'h04;
    localparam logic [7:0] OFS_CNT_LO   = 8'h08;
    localparam logic [7:0] OFS_CNT_HI   = 8'h0C;
    localparam logic [7:0] OFS_SCRATCH  = 8'h10;
    localparam logic [7:0] OFS_WR_COUNT = 8'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        strb_merge = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) strb_merge[b*8 +: 8] = new_v[b*8 +: 8];
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle (AW/W/B/AR/R) with master and slave views.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_slave_if_fsm.sv
// AXI4-Lite slave handshake engine. Turns AW/W and AR into single-cycle
// register-access strobes and returns the register file's data/error as
// B and R responses. One write and one read outstanding at most.
module axil_slave_if_fsm
    import axil_time_meter_pkg::*;
#(
    parameter int DW = 32,
    parameter int AL = 8
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi4_lite_if.slave      axi,
    output logic            wr_en,
    output logic [AL-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [DW/8-1:0] wr_strb,
    input  logic            wr_err,
    output logic            rd_en,
    output logic [AL-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    input  logic            rd_err
);

    wr_state_t       w_state;
    rd_state_t       r_state;
    logic            aw_held, w_held;
    logic [AL-1:0]   aw_addr_q;
    logic [DW-1:0]   w_data_q;
    logic [DW/8-1:0] w_strb_q;
    logic            aw_hs, w_hs, ar_hs;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    // A channel arriving this cycle is forwarded directly so the register
    // update lands on the same edge as the last handshake.
    assign wr_addr = aw_held ? aw_addr_q : axi.awaddr[AL-1:0];
    assign wr_data = w_held  ? w_data_q  : axi.wdata;
    assign wr_strb = w_held  ? w_strb_q  : axi.wstrb;
    assign wr_en   = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign rd_en   = ar_hs;
    assign rd_addr = axi.araddr[AL-1:0];

    // Write path: latch AW and W independently, fire once both are held, then hold B.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state     <= W_IDLE;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= RESP_OKAY;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_en) begin
                        w_state     <= W_RESP;
                        axi.bvalid  <= 1'b1;
                        axi.bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b0;
                        aw_held     <= 1'b0;
                        w_held      <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= axi.awaddr[AL-1:0];
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= axi.wdata;
                            w_strb_q <= axi.wstrb;
                        end
                        axi.awready <= !(aw_held || aw_hs);
                        axi.wready  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        w_state     <= W_IDLE;
                        axi.bvalid  <= 1'b0;
                        axi.awready <= 1'b1;
                        axi.wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: capture register data on AR handshake, hold R until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= R_IDLE;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state     <= R_DATA;
                        axi.arready <= 1'b0;
                        axi.rvalid  <= 1'b1;
                        axi.rdata   <= rd_data;
                        axi.rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        axi.arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        r_state     <= R_IDLE;
                        axi.rvalid  <= 1'b0;
                        axi.arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axil_time_meter.sv
// AXI4-Lite time meter: free-running 64-bit cycle counter with a hi-word
// snapshot taken on every CNT_LO read, plus ID, CTRL, SCRATCH and a count
// of successfully completed writes.
module axil_time_meter
    import axil_time_meter_pkg::*;
#(
    parameter int          AW            = 32,
    parameter int          DW            = 32,
    parameter logic [31:0] ID_VALUE      = 32'h544D_0001,
    parameter int          ADDR_LSB_MASK = 8
) (
    input  logic       aclk,
    input  logic       aresetn,
    axi4_lite_if.slave axi
);

    localparam int AL = ADDR_LSB_MASK;

    if (DW != 32) begin : g_dw_chk
        $error("axil_time_meter: only DW=32 is supported");
    end
    if (AL > AW) begin : g_al_chk
        $error("axil_time_meter: ADDR_LSB_MASK exceeds AW");
    end

    localparam logic [AL-1:0] A_ID       = AL'(OFS_ID);
    localparam logic [AL-1:0] A_CTRL     = AL'(OFS_CTRL);
    localparam logic [AL-1:0] A_CNT_LO   = AL'(OFS_CNT_LO);
    localparam logic [AL-1:0] A_CNT_HI   = AL'(OFS_CNT_HI);
    localparam logic [AL-1:0] A_SCRATCH  = AL'(OFS_SCRATCH);
    localparam logic [AL-1:0] A_WR_COUNT = AL'(OFS_WR_COUNT);

    logic            wr_en, wr_err, rd_en, rd_err;
    logic [AL-1:0]   wr_addr, rd_addr;
    logic [DW-1:0]   wr_data, rd_data;
    logic [DW/8-1:0] wr_strb;

    logic        ctrl_en;
    logic [63:0] cnt_q;
    logic [31:0] snap_q, scratch_q, wr_count_q;
    logic        wr_ok, clr;

    axil_slave_if_fsm #(.DW(DW), .AL(AL)) u_if (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (axi),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_err  (wr_err),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_err  (rd_err)
    );

    // Only CTRL and SCRATCH accept writes; RO and unmapped offsets error out.
    always_comb begin
        wr_err = 1'b1;
        if (wr_addr == A_CTRL || wr_addr == A_SCRATCH) wr_err = 1'b0;
    end

    assign wr_ok = wr_en && !wr_err;
    assign clr   = wr_ok && (wr_addr == A_CTRL) && wr_strb[0] && wr_data[1];

    // Read mux; CLR is self-clearing so CTRL only ever shows EN.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_addr)
            A_ID:       rd_data = ID_VALUE;
            A_CTRL:     rd_data[0] = ctrl_en;
            A_CNT_LO:   rd_data = cnt_q[31:0];
            A_CNT_HI:   rd_data = snap_q;
            A_SCRATCH:  rd_data = scratch_q;
            A_WR_COUNT: rd_data = wr_count_q;
            default:    rd_err = 1'b1;
        endcase
    end

    // Software-visible RW registers and the count of OKAY writes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_en    <= 1'b0;
            scratch_q  <= '0;
            wr_count_q <= '0;
        end else if (wr_ok) begin
            wr_count_q <= wr_count_q + 32'd1;
            if (wr_addr == A_CTRL && wr_strb[0]) ctrl_en <= wr_data[0];
            if (wr_addr == A_SCRATCH) scratch_q <= strb_merge(scratch_q, wr_data, wr_strb);
        end
    end

    // Cycle counter: CLR wins over EN; EN written this cycle takes effect next cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)     cnt_q <= '0;
        else if (clr)     cnt_q <= '0;
        else if (ctrl_en) cnt_q <= cnt_q + 64'd1;
    end

    // Hi-word snapshot taken alongside a CNT_LO read (pre-clear value if CLR coincides).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                           snap_q <= '0;
        else if (rd_en && rd_addr == A_CNT_LO)  snap_q <= cnt_q[63:32];
    end

endmodule

// File: tb/tb_axil_time_meter.sv
// Directed bench for axil_time_meter. All stimulus is driven and all
// outputs sampled on the falling clock edge.
module tb_axil_time_meter;
    import axil_time_meter_pkg::*;

    logic aclk;
    logic aresetn;
    int   n_chk = 0;
    int   n_err = 0;

    axi4_lite_if #(.AW(32), .DW(32)) axi ();

    axil_time_meter #(
        .AW(32), .DW(32), .ID_VALUE(32'h544D_0001), .ADDR_LSB_MASK(8)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (axi)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Finish any pending AW/W handshakes, then collect the B response.
    task automatic wr_finish(output logic [1:0] resp);
        logic aw_go, w_go;
        int   n;
        n = 0;
        while ((axi.awvalid || axi.wvalid) && n < 50) begin
            aw_go = axi.awvalid && axi.awready;
            w_go  = axi.wvalid && axi.wready;
            @(negedge aclk);
            if (aw_go) axi.awvalid = 1'b0;
            if (w_go)  axi.wvalid  = 1'b0;
            n++;
        end
        if (axi.awvalid || axi.wvalid) chk("wr_hs_timeout", {axi.awvalid, axi.wvalid}, 2'b00);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        n = 0;
        while (!axi.bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (axi.bvalid !== 1'b1) begin
            chk("b_timeout", axi.bvalid, 1'b1);
            resp = 2'b11;
        end else begin
            resp = axi.bresp;
            axi.bready = 1'b1;
            @(negedge aclk);
            axi.bready = 1'b0;
        end
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
        axi.awaddr  = a;
        axi.wdata   = d;
        axi.wstrb   = s;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        wr_finish(resp);
    endtask

    // lat counts falling edges waited after the AR handshake edge; 0 means
    // rvalid was up one cycle after the handshake.
    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
        logic go;
        int   n;
        axi.araddr  = a;
        axi.arvalid = 1'b1;
        n = 0;
        while (axi.arvalid && n < 50) begin
            go = axi.arready;
            @(negedge aclk);
            if (go) axi.arvalid = 1'b0;
            n++;
        end
        if (axi.arvalid) chk("ar_timeout", axi.arvalid, 1'b0);
        axi.arvalid = 1'b0;
        lat = 0;
        while (!axi.rvalid && lat < 50) begin
            @(negedge aclk);
            lat++;
        end
        if (axi.rvalid !== 1'b1) chk("r_timeout", axi.rvalid, 1'b1);
        d    = axi.rdata;
        resp = axi.rresp;
        axi.rready = 1'b1;
        @(negedge aclk);
        axi.rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        axi_rd(a, d, r, lat);
        chk(tag, d, exp_d);
        chk({tag, "_resp"}, r, exp_r);
    endtask

    initial begin
        logic [31:0] d, v1, v2;
        logic [1:0]  r;
        int          lat;
        logic        go, ok;
        int          exp_wrc;

        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 0;  axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
        aresetn = 1'b0;
        exp_wrc = 0;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_valid_ready", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}, 5'b0);
        chk("rst_rdata", axi.rdata, 32'h0);
        chk("rst_resp", {axi.bresp, axi.rresp}, 4'b0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("idle_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);

        // ID and unmapped reads, upper address bits ignored
        axi_rd(32'h00, d, r, lat);
        chk("id_data", d, 32'h544D_0001);
        chk("id_resp", r, RESP_OKAY);
        chk("id_lat", lat, 0);
        rd_chk("unmapped_rd", 32'h40, 32'h0, RESP_SLVERR);
        rd_chk("id_alias", 32'h1000_0000, 32'h544D_0001, RESP_OKAY);
        rd_chk("rst_ctrl", 32'h04, 32'h0, RESP_OKAY);
        rd_chk("rst_scratch", 32'h10, 32'h0, RESP_OKAY);
        rd_chk("rst_wrc", 32'h14, 32'h0, RESP_OKAY);
        rd_chk("rst_cnt_lo", 32'h08, 32'h0, RESP_OKAY);

        // SCRATCH with AW well ahead of W, partial strobe
        axi.awaddr = 32'h10; axi.awvalid = 1'b1;
        go = axi.awready;
        @(negedge aclk);
        axi.awvalid = 1'b0;
        chk("aw_early_hs", go, 1'b1);
        repeat (3) @(negedge aclk);
        chk("no_b_before_w", axi.bvalid, 1'b0);
        chk("aw_held_ready", axi.awready, 1'b0);
        axi.wdata = 32'hFFFF_FFFF; axi.wstrb = 4'b0101; axi.wvalid = 1'b1;
        go = axi.wready;
        @(negedge aclk);
        axi.wvalid = 1'b0;
        chk("w_late_hs", go, 1'b1);
        chk("b_lat_1", axi.bvalid, 1'b1);
        chk("scratch_bresp", axi.bresp, RESP_OKAY);
        axi.bready = 1'b1;
        @(negedge aclk);
        axi.bready = 1'b0;
        exp_wrc++;
        rd_chk("scratch_strb", 32'h10, 32'h00FF_00FF, RESP_OKAY);
        rd_chk("wrc_1", 32'h14, exp_wrc, RESP_OKAY);

        // Enable counter and let it run ~100 cycles
        axi_wr(32'h04, 32'h1, 4'hF, r); exp_wrc++;
        chk("ctrl_en_bresp", r, RESP_OKAY);
        repeat (100) @(negedge aclk);
        axi_rd(32'h08, d, r, lat);
        chk("cnt_lo_100", (d >= 32'd97 && d <= 32'd103), 1'b1);
        rd_chk("cnt_hi_0", 32'h0C, 32'h0, RESP_OKAY);
        rd_chk("ctrl_rd_en", 32'h04, 32'h1, RESP_OKAY);

        // Low-word wrap: preload just below a 2^32 boundary
        axi_wr(32'h04, 32'h0, 4'hF, r); exp_wrc++;
        force dut.cnt_q = 64'h0000_0001_FFFF_FFF0;
        @(negedge aclk);
        release dut.cnt_q;
        rd_chk("preload_lo", 32'h08, 32'hFFFF_FFF0, RESP_OKAY);
        rd_chk("preload_hi", 32'h0C, 32'h1, RESP_OKAY);
        axi_wr(32'h04, 32'h1, 4'hF, r); exp_wrc++;
        repeat (40) @(negedge aclk);
        axi_rd(32'h08, d, r, lat);
        chk("wrap_lo_small", d < 32'h100, 1'b1);
        rd_chk("wrap_hi_snap", 32'h0C, 32'h2, RESP_OKAY);

        // B backpressure: second write must wait for the B handshake
        axi.awaddr = 32'h10; axi.wdata = 32'h1111_1111; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        go = axi.awready && axi.wready;
        @(negedge aclk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        chk("bp_first_hs", go, 1'b1);
        chk("bp_bvalid", axi.bvalid, 1'b1);
        axi.wdata = 32'h2222_2222; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            if (!axi.bvalid || axi.awready || axi.wready) ok = 1'b0;
        end
        chk("bp_hold", ok, 1'b1);
        chk("bp_bresp", axi.bresp, RESP_OKAY);
        axi.bready = 1'b1;
        @(negedge aclk);
        axi.bready = 1'b0;
        exp_wrc++;
        chk("bp_b_drop", axi.bvalid, 1'b0);
        wr_finish(r); exp_wrc++;
        chk("bp_second_bresp", r, RESP_OKAY);
        rd_chk("bp_scratch", 32'h10, 32'h2222_2222, RESP_OKAY);
        rd_chk("bp_wrc", 32'h14, exp_wrc, RESP_OKAY);

        // CLR with EN: counter restarts from zero and keeps counting
        axi_wr(32'h04, 32'h3, 4'hF, r); exp_wrc++;
        repeat (495) @(negedge aclk);
        axi_wr(32'h04, 32'h3, 4'hF, r); exp_wrc++;
        chk("clr_bresp", r, RESP_OKAY);
        axi_rd(32'h08, v1, r, lat);
        chk("clr_lo_small", v1 < 32'd5, 1'b1);
        rd_chk("clr_hi", 32'h0C, 32'h0, RESP_OKAY);
        rd_chk("clr_ctrl_rd", 32'h04, 32'h1, RESP_OKAY);
        repeat (20) @(negedge aclk);
        axi_rd(32'h08, v2, r, lat);
        chk("clr_continues", v2 > v1, 1'b1);

        // RO and unmapped writes: SLVERR, nothing changes
        axi_wr(32'h04, 32'h0, 4'hF, r); exp_wrc++;
        axi_rd(32'h08, v1, r, lat);
        axi_wr(32'h08, 32'h2, 4'hF, r);
        chk("ro_cnt_lo_bresp", r, RESP_SLVERR);
        axi_wr(32'h00, 32'h1234, 4'hF, r);
        chk("ro_id_bresp", r, RESP_SLVERR);
        axi_wr(32'h40, 32'h5, 4'hF, r);
        chk("unmapped_bresp", r, RESP_SLVERR);
        rd_chk("ro_cnt_kept", 32'h08, v1, RESP_OKAY);
        rd_chk("ro_scratch_kept", 32'h10, 32'h2222_2222, RESP_OKAY);
        rd_chk("ro_wrc", 32'h14, exp_wrc, RESP_OKAY);
        rd_chk("ro_id_kept", 32'h00, 32'h544D_0001, RESP_OKAY);

        // CNT_LO read and CLR write on the same edge
        force dut.cnt_q = 64'h0000_0005_0000_1234;
        @(negedge aclk);
        release dut.cnt_q;
        axi.araddr = 32'h08; axi.arvalid = 1'b1;
        axi.awaddr = 32'h04; axi.wdata = 32'h2; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        go = axi.arready && axi.awready && axi.wready;
        @(negedge aclk);
        axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        chk("sim_ready", go, 1'b1);
        chk("sim_valids", {axi.rvalid, axi.bvalid}, 2'b11);
        chk("sim_lo_preclr", axi.rdata, 32'h0000_1234);
        chk("sim_bresp", axi.bresp, RESP_OKAY);
        axi.rready = 1'b1; axi.bready = 1'b1;
        @(negedge aclk);
        axi.rready = 1'b0; axi.bready = 1'b0;
        exp_wrc++;
        rd_chk("sim_hi_preclr", 32'h0C, 32'h5, RESP_OKAY);
        rd_chk("sim_lo_cleared", 32'h08, 32'h0, RESP_OKAY);
        rd_chk("sim_hi_cleared", 32'h0C, 32'h0, RESP_OKAY);
        rd_chk("sim_wrc", 32'h14, exp_wrc, RESP_OKAY);

        // Reset while R is pending
        axi.araddr = 32'h10; axi.arvalid = 1'b1;
        @(negedge aclk);
        axi.arvalid = 1'b0;
        chk("pend_rvalid", axi.rvalid, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rvalid_drop", axi.rvalid, 1'b0);
        chk("async_ready_drop", {axi.arready, axi.awready, axi.wready}, 3'b000);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        rd_chk("post_rst_id", 32'h00, 32'h544D_0001, RESP_OKAY);
        rd_chk("post_rst_ctrl", 32'h04, 32'h0, RESP_OKAY);
        rd_chk("post_rst_scratch", 32'h10, 32'h0, RESP_OKAY);
        rd_chk("post_rst_wrc", 32'h14, 32'h0, RESP_OKAY);
        rd_chk("post_rst_lo", 32'h08, 32'h0, RESP_OKAY);
        rd_chk("post_rst_hi", 32'h0C, 32'h0, RESP_OKAY);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axil_time_meter.md
Name: axil_time_meter

Overview:
- AXI4-Lite slave register block placed downstream of the PCIe bridge's AXI4-Lite master, alongside mem_wrapper, on its own address window.
- Gives host software a free-running 64-bit cycle counter with an atomic hi/lo snapshot, a control register, a scratch register and a write-transaction counter.
- Used to time PCIe round trips and to check the bus path.

Parameters:
- AW, 32, AXI address width.
- DW, 32, AXI data width. Only 32 is supported; any other value is an elaboration error.
- ID_VALUE, 32'h544D_0001, constant returned by the ID register.
- ADDR_LSB_MASK, 8, number of low address bits decoded. Higher address bits are ignored.

Ports:
- aclk, input, 1, sole clock.
- aresetn, input, 1, asynchronous active-low reset.
- axi, interface, axi4_lite_if #(.DW(DW), .AW(AW)) slave side, carries the AW/W/B/AR/R channels.

Behaviour:
- Reset: all outputs are driven low while aresetn=0. This covers awready, wready, bvalid, arready, rvalid, rdata=0 and bresp/rresp=0.
- Reset register values: CTRL=0 (counter disabled), counter=0, snapshot=0, SCRATCH=0, WR_COUNT=0.
- Register map, at address[ADDR_LSB_MASK-1:0]:
  - 0x00 ID, RO, reads ID_VALUE.
  - 0x04 CTRL, RW. bit0 = EN. bit1 = CLR, write-1 self-clearing, reads 0. Other bits read 0.
  - 0x08 CNT_LO, RO. Returns counter[31:0] and, in the same cycle, latches counter[63:32] into the snapshot.
  - 0x0C CNT_HI, RO. Returns the snapshot.
  - 0x10 SCRATCH, RW, honours WSTRB per byte.
  - 0x14 WR_COUNT, RO. Counts write responses with OKAY, 32-bit, wraps.
- Unmapped offsets:
  - Read: rdata=0, rresp=SLVERR (2'b10).
  - Write: no register changes, bresp=SLVERR, WR_COUNT is not incremented.
  - Writes to RO registers also return SLVERR.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured. AW and W may arrive in either order or together; each is latched independently.
  - Once both are held, the register is updated in that cycle and the FSM moves to W_RESP with bvalid=1 on the next cycle. Latency from the last of AW/W to bvalid is 1 cycle.
  - In W_RESP, awready=wready=0. bvalid stays high until bready=1, then return to W_IDLE.
  - One write is outstanding at most.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, arready=1. On arvalid, register data is captured and rvalid=1 on the next cycle (1-cycle latency).
  - In R_DATA, arready=0. rdata/rresp are held stable until rready=1, then return to R_IDLE.
- Read and write FSMs run independently; a read and a write may complete in the same cycle.
- Counter:
  - Each cycle: if CLR was written this cycle, counter=0. Otherwise, if EN=1, counter increments by 1. 64-bit, wraps 2^64-1 -> 0.
  - A CTRL write with EN=1 and CLR=1 clears the counter that cycle and counts from the next cycle.
- Simultaneous CNT_LO read and CLR write: the read returns the pre-clear value and the snapshot latches the pre-clear high word.
- aresetn asserted mid-transaction aborts both FSMs to IDLE and drops all valids asynchronously. No response is issued for the aborted transaction.

Decomposition:
- Package axil_time_meter_pkg holds:
  - register offset localparams: OFS_ID, OFS_CTRL, OFS_CNT_LO, OFS_CNT_HI, OFS_SCRATCH, OFS_WR_COUNT;
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - FSM state enums wr_state_t and rd_state_t.
- One sub-module, axil_slave_if_fsm. It handles the AXI handshakes and emits single-cycle wr_en/addr/data/strb and rd_en/addr, and accepts rd_data and error flags.
- The top-level module holds the register file and the counter.

Test Plan:
- Reset, then read 0x00 -> rdata=32'h544D_0001, rresp=OKAY, rvalid 1 cycle after AR handshake. A read of 0x40 -> rdata=0, rresp=SLVERR.
- Write SCRATCH 0xFFFF_FFFF with WSTRB=4'b0101, having AW 3 cycles before W -> bvalid 1 cycle after W. A readback of 0x10 -> 0x00FF_00FF, and WR_COUNT reads 1.
- Write CTRL=1, wait 100 cycles, read CNT_LO then CNT_HI -> CNT_LO in 100±3 and CNT_HI=0. Preload near wrap via 2^32 cycles, or via a force in the bench -> hi snapshot is consistent with lo.
- Hold bready=0 for 10 cycles after a write -> bvalid stays 1, awready/wready stay 0, and a second AW is not accepted until the B handshake.
- Write CTRL=3 while counter=500 -> next read of CNT_LO returns a small value (<5) and counting continues. A write to 0x08 -> bresp=SLVERR and the counter is unaffected.
- Assert aresetn=0 while rvalid=1 with rready=0 -> rvalid drops immediately. After release, all registers are at reset values and ID reads correctly.
